// File: rtl/disp_scan_ctrl.sv
// disp_scan_ctrl: memory-mapped 4-digit seven-segment scan controller with hex decode, blanking, dp and PWM
//   clk        : system clock, all state on posedge
//   reset      : asynchronous, active-high
//   Address    : bus byte address, exact 32-bit match against VAL_ADDR / CTRL_ADDR
//   Write_data : bus write data
//   MemRead    : bus read strobe, gates the combinational Rd_data
//   MemWrite   : bus write strobe, sampled on posedge clk
//   Rd_data    : val or ctrl zero-extended when addressed, else 0
//   an         : active-low digit enables, an[0] = least significant digit
//   seg        : active-low segments, seg[7] = dp, seg[6:0] = g,f,e,d,c,b,a
module disp_scan_ctrl #(
    parameter int          SCAN_DIV  = 50000,
    parameter logic [31:0] VAL_ADDR  = 32'h40000014,
    parameter logic [31:0] CTRL_ADDR = 32'h40000018
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [31:0] Address,
    input  logic [31:0] Write_data,
    input  logic        MemRead,
    input  logic        MemWrite,
    output logic [31:0] Rd_data,
    output logic [3:0]  an,
    output logic [7:0]  seg
);
    localparam int CW = $clog2(SCAN_DIV);
    localparam logic [CW-1:0] SLOT_MAX = CW'(SCAN_DIV - 1);

    logic [15:0]   val;
    logic [15:0]   shadow;
    logic [11:0]   ctrl;
    logic [CW-1:0] slot_cnt;
    logic [1:0]    digit;
    logic [3:0]    pwm_cnt;
    logic          wrap;
    logic          frame_end;
    logic          lit;
    logic          blank;
    logic [15:0]   upper;
    logic [6:0]    glyph;

    assign wrap      = slot_cnt == SLOT_MAX;
    assign frame_end = wrap && digit == 2'd3;
    assign lit       = ctrl[0] && pwm_cnt < ctrl[7:4];
    // upper holds the current nibble and everything above it; zero means a leading zero
    assign upper     = shadow >> {digit, 2'b00};
    assign blank     = ctrl[1] && digit != 2'd0 && upper == 16'h0;

    assign Rd_data = !MemRead             ? 32'h0 :
                     Address == VAL_ADDR  ? {16'h0, val} :
                     Address == CTRL_ADDR ? {20'h0, ctrl} : 32'h0;

    always_comb begin
        glyph = 7'h7F;
        case (upper[3:0])
            4'h0: glyph = 7'h40;
            4'h1: glyph = 7'h79;
            4'h2: glyph = 7'h24;
            4'h3: glyph = 7'h30;
            4'h4: glyph = 7'h19;
            4'h5: glyph = 7'h12;
            4'h6: glyph = 7'h02;
            4'h7: glyph = 7'h78;
            4'h8: glyph = 7'h00;
            4'h9: glyph = 7'h10;
            4'hA: glyph = 7'h08;
            4'hB: glyph = 7'h03;
            4'hC: glyph = 7'h46;
            4'hD: glyph = 7'h21;
            4'hE: glyph = 7'h06;
            4'hF: glyph = 7'h0E;
            default: glyph = 7'h7F;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            val      <= 16'h0;
            ctrl     <= 12'h0F1;
            shadow   <= 16'h0;
            slot_cnt <= '0;
            digit    <= 2'd0;
            pwm_cnt  <= 4'd0;
            an       <= 4'hF;
            seg      <= 8'hFF;
        end else begin
            if (MemWrite && Address == VAL_ADDR)
                val <= Write_data[15:0];
            if (MemWrite && Address == CTRL_ADDR)
                ctrl <= Write_data[11:0];
            // shadow samples the pre-edge val, so a write on the boundary cycle waits a frame
            if (!ctrl[0] || frame_end)
                shadow <= val;
            slot_cnt <= wrap ? '0 : slot_cnt + CW'(1);
            if (wrap)
                digit <= digit + 2'd1;
            pwm_cnt <= pwm_cnt + 4'd1;
            an      <= lit ? ~(4'b0001 << digit) : 4'hF;
            seg     <= lit ? {~ctrl[8 + int'(digit)], blank ? 7'h7F : glyph} : 8'hFF;
        end
    end
endmodule

// File: tb/tb_disp_scan_ctrl.sv
// tb_disp_scan_ctrl: scoreboard bench for disp_scan_ctrl against a time-based reference model
module tb_disp_scan_ctrl;
    localparam int          SD = 4;
    localparam int          F  = 4 * SD;
    localparam logic [31:0] VA = 32'h40000014;
    localparam logic [31:0] CA = 32'h40000018;
    localparam logic [31:0] NA = 32'h40000010;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic [31:0] Address = 32'h0;
    logic [31:0] Write_data = 32'h0;
    logic        MemRead = 1'b0;
    logic        MemWrite = 1'b0;
    logic [31:0] Rd_data;
    logic [3:0]  an;
    logic [7:0]  seg;

    always #5 clk = ~clk;

    disp_scan_ctrl #(.SCAN_DIV(SD), .VAL_ADDR(VA), .CTRL_ADDR(CA)) dut (
        .clk(clk), .reset(reset), .Address(Address), .Write_data(Write_data),
        .MemRead(MemRead), .MemWrite(MemWrite), .Rd_data(Rd_data), .an(an), .seg(seg)
    );

    int checks = 0;
    int failures = 0;

    typedef struct packed { logic [3:0] an; logic [7:0] seg; } out_t;
    out_t        out_q[$];
    logic [31:0] rd_q[$];

    logic [7:0] glyph_tab [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                                   8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // model state: t counts clock edges since reset release; scan position is derived from it
    logic [15:0] m_val = 16'h0;
    logic [15:0] m_shadow = 16'h0;
    logic [11:0] m_ctrl = 12'h0F1;
    int          t = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s at %0t: got=%h want=%h", name, $time, act, exp);
        end
    endtask

    function automatic out_t expect_out();
        int          d = (t / SD) % 4;
        int          p = t % 16;
        logic [15:0] upper;
        out_t        o;
        o.an  = 4'hF;
        o.seg = 8'hFF;
        if (m_ctrl[0] && p < int'(m_ctrl[7:4])) begin
            upper     = m_shadow >> (4 * d);
            o.an      = 4'hF ^ 4'(1 << d);
            o.seg[7]  = ~m_ctrl[8 + d];
            o.seg[6:0] = (m_ctrl[1] && d > 0 && upper == 16'h0) ? 7'h7F : glyph_tab[upper[3:0]][6:0];
        end
        return o;
    endfunction

    always @(posedge clk) begin
        if (reset) begin
            m_val    <= 16'h0;
            m_ctrl   <= 12'h0F1;
            m_shadow <= 16'h0;
            t        <= 0;
        end else begin
            out_q.push_back(expect_out());
            if (!m_ctrl[0] || t % F == F - 1)
                m_shadow <= m_val;
            if (MemWrite && Address == VA)
                m_val <= Write_data[15:0];
            if (MemWrite && Address == CA)
                m_ctrl <= Write_data[11:0];
            t <= t + 1;
        end
    end

    always @(negedge clk) begin : monitor
        out_t o;
        if (reset) begin
            chk("reset_an", {28'h0, an}, 32'hF);
            chk("reset_seg", {24'h0, seg}, 32'hFF);
        end else if (out_q.size() > 0) begin
            o = out_q.pop_front();
            chk("an", {28'h0, an}, {28'h0, o.an});
            chk("seg", {24'h0, seg}, {24'h0, o.seg});
        end
        if (MemRead) begin
            if (rd_q.size() > 0)
                chk("rd_data", Rd_data, rd_q.pop_front());
            else
                chk("rd_underflow", 32'h1, 32'h0);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        Address = a;
        Write_data = d;
        MemWrite = 1'b1;
        tick(1);
        MemWrite = 1'b0;
    endtask

    task automatic rd(input logic [31:0] a);
        Address = a;
        MemRead = 1'b1;
        rd_q.push_back(a == VA ? {16'h0, m_val} : a == CA ? {20'h0, m_ctrl} : 32'h0);
        tick(1);
        MemRead = 1'b0;
    endtask

    task automatic sync_to(input int m, input int ph);
        int n = 0;
        while (t % m != ph && n < 4 * F) begin
            tick(1);
            n++;
        end
        if (t % m != ph)
            chk("sync_timeout", 32'h1, 32'h0);
    endtask

    task automatic do_reset();
        #3 reset = 1'b1;
        out_q.delete();
        #1;
        chk("async_an", {28'h0, an}, 32'hF);
        chk("async_seg", {24'h0, seg}, 32'hFF);
        tick(1);
        rd(CA);
        rd(VA);
        reset = 1'b0;
    endtask

    initial begin
        int cnt;
        #1 reset = 1'b1;
        tick(2);
        rd(CA);
        rd(VA);
        rd(NA);
        reset = 1'b0;
        tick(3);
        // hex glyphs and frame-boundary load
        wr(VA, 32'hFFFF1A5F);
        tick(2 * F);
        // mid-frame write held until boundary, then a write exactly on the boundary edge
        sync_to(F, SD + 1);
        wr(VA, 32'h2222);
        rd(VA);
        tick(F);
        sync_to(F, F - 1);
        wr(VA, 32'h3B7C);
        rd(VA);
        tick(2 * F);
        // leading-zero blanking with dp on digit 2
        wr(CA, 32'h4F3);
        wr(VA, 32'h0005);
        tick(2 * F);
        wr(VA, 32'h0000);
        tick(2 * F);
        wr(VA, 32'h0D00);
        tick(2 * F);
        // brightness
        wr(CA, 32'h001);
        tick(F);
        wr(CA, 32'h081);
        tick(3);
        cnt = 0;
        repeat (16) begin
            @(negedge clk);
            if (an !== 4'hF) cnt++;
        end
        chk("bright8_duty", cnt, 8);
        tick(1);
        // disabled: shadow follows val without waiting for a boundary
        wr(CA, 32'h0F0);
        wr(VA, 32'hC0DE);
        tick(3);
        wr(CA, 32'h0F1);
        tick(SD * 2);
        wr(NA, 32'h1234);
        rd(CA);
        // random traffic
        for (int i = 0; i < 250; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2: wr(VA, $urandom);
                3: wr(CA, {$urandom} & 32'hFFFF_FFFE | 32'($urandom_range(0, 3) != 0));
                4: rd(VA);
                5: rd(($urandom_range(0, 1) != 0) ? CA : NA);
                6: begin sync_to(F, F - 1); wr(VA, $urandom); end
                7: wr(($urandom_range(0, 1) != 0) ? NA : $urandom, $urandom);
                default: tick($urandom_range(1, 6));
            endcase
        end
        // reset mid-slot at digit 2 with non-default registers
        wr(CA, 32'hA53);
        wr(VA, 32'h9876);
        tick(F);
        sync_to(F, 2 * SD + 1);
        do_reset();
        tick(2 * F);
        rd(CA);
        tick(2);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end
endmodule
